// File: rtl/branch_predict_check.sv
// -----------------------------------------------------------------------------
// branch_predict_check
//
// Branch resolution and dynamic prediction unit for the MIPS pipeline.
//   * Resolves the six MIPS branch conditions in ID from forwarded operands.
//   * Holds a branch history table (BHT) of 2-bit saturating counters indexed
//     by pc[IDX+1:2]. IF gets its prediction from the MSB of the counter.
//   * Flags a mispredict (flush request) when the resolved outcome differs
//     from the prediction that travelled down from IF.
//
// Optional feature macro: BRANCH_STATS_EN
//   When defined, adds resolve and mispredict event counters with a
//   synchronous clear input.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset; BHT entries reset to 01
//   if_pc            fetch PC used for the prediction lookup
//   pred_taken       combinational prediction for if_pc
//   id_valid         ID stage holds a valid instruction
//   id_pc            PC of the instruction in ID (selects the BHT entry)
//   id_pred_taken    prediction made for id_pc back in IF
//   in1, in2         forwarded rs/rt operands
//   stall_compare    operands not ready; blocks resolution and BHT update
//   branch_condition 3-bit condition code
//   branch_check     resolved outcome (taken), combinational
//   mispredict       outcome differs from id_pred_taken, combinational
//   stats_clear      (BRANCH_STATS_EN) synchronous clear of both counters
//   branch_count     (BRANCH_STATS_EN) number of resolve events
//   mispredict_count (BRANCH_STATS_EN) number of mispredicts
// -----------------------------------------------------------------------------
module branch_predict_check #(
    parameter int WIDTH     = 32,
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                pred_taken,
    input  logic                id_valid,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic                id_pred_taken,
    input  logic [WIDTH-1:0]    in1,
    input  logic [WIDTH-1:0]    in2,
    input  logic                stall_compare,
    input  logic [2:0]          branch_condition,
`ifdef BRANCH_STATS_EN
    input  logic                stats_clear,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count,
`endif
    output logic                branch_check,
    output logic                mispredict
);

    localparam int IDX = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        COND_NONE = 3'b000,
        COND_BEQ  = 3'b001,
        COND_BNE  = 3'b010,
        COND_BLEZ = 3'b011,
        COND_BGTZ = 3'b100,
        COND_BLTZ = 3'b101,
        COND_BGEZ = 3'b110,
        COND_RSVD = 3'b111
    } cond_code_e;

    // Next value of a 2-bit saturating counter for a resolved outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : (ctr + 2'b01);
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : (ctr - 2'b01);
        end
        return nxt;
    endfunction

    logic [1:0]     bht_r [BHT_DEPTH];
    logic [IDX-1:0] lookup_idx_s;
    logic [IDX-1:0] update_idx_s;
    logic           cond_true_s;
    logic           is_branch_s;
    logic           resolve_s;
    logic           in1_neg_s;
    logic           in1_zero_s;
    logic           unused_pc_bits_s;

    // Word-aligned PCs: drop the byte offset, upper bits alias onto the table.
    assign lookup_idx_s = if_pc[IDX+1:2];
    assign update_idx_s = id_pc[IDX+1:2];
    assign unused_pc_bits_s = ^{if_pc[PC_WIDTH-1:IDX+2], if_pc[1:0],
                                id_pc[PC_WIDTH-1:IDX+2], id_pc[1:0]};

    assign in1_neg_s  = in1[WIDTH-1];
    assign in1_zero_s = (in1 == {WIDTH{1'b0}});

    // Condition evaluation; the zero-compare codes look only at in1.
    always_comb begin
        cond_true_s = 1'b0;
        is_branch_s = 1'b0;
        case (branch_condition)
            COND_BEQ:  begin is_branch_s = 1'b1; cond_true_s = (in1 == in2); end
            COND_BNE:  begin is_branch_s = 1'b1; cond_true_s = (in1 != in2); end
            COND_BLEZ: begin is_branch_s = 1'b1; cond_true_s = in1_neg_s | in1_zero_s; end
            COND_BGTZ: begin is_branch_s = 1'b1; cond_true_s = ~in1_neg_s & ~in1_zero_s; end
            COND_BLTZ: begin is_branch_s = 1'b1; cond_true_s = in1_neg_s; end
            COND_BGEZ: begin is_branch_s = 1'b1; cond_true_s = ~in1_neg_s; end
            COND_NONE: begin is_branch_s = 1'b0; cond_true_s = 1'b0; end
            COND_RSVD: begin is_branch_s = 1'b0; cond_true_s = 1'b0; end
            default:   begin is_branch_s = 1'b0; cond_true_s = 1'b0; end
        endcase
    end

    assign resolve_s = id_valid & ~stall_compare & is_branch_s;

    // Resolution outputs and fetch prediction; no bypass from a same-cycle update.
    always_comb begin
        branch_check = 1'b0;
        mispredict   = 1'b0;
        pred_taken   = bht_r[lookup_idx_s][1];
        if (resolve_s) begin
            branch_check = cond_true_s;
            mispredict   = cond_true_s ^ id_pred_taken;
        end else begin
            branch_check = 1'b0;
            mispredict   = 1'b0;
        end
    end

    // BHT counter storage; reset drops any update pending in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (resolve_s) begin
            bht_r[update_idx_s] <= sat_update(bht_r[update_idx_s], cond_true_s);
        end else begin
            bht_r[update_idx_s] <= bht_r[update_idx_s];
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_r;
    logic [31:0] mispredict_count_r;

    // Event counters; clear wins over a same-cycle increment, wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else if (stats_clear) begin
            branch_count_r     <= 32'd0;
            mispredict_count_r <= 32'd0;
        end else begin
            branch_count_r     <= branch_count_r + {31'd0, resolve_s};
            mispredict_count_r <= mispredict_count_r + {31'd0, mispredict};
        end
    end

    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;
`endif

endmodule

// File: tb/tb_branch_predict_check.sv
// -----------------------------------------------------------------------------
// Self-checking bench for branch_predict_check (WIDTH=32, PC_WIDTH=32,
// BHT_DEPTH=64). A behavioural model keeps the predictor as an integer array
// of counter values 0..3 and evaluates branch conditions with signed integer
// arithmetic. Directed sequences cover reset, signed compares, saturation,
// stalls, aliasing and mid-operation reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_branch_predict_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        stall_compare;
    logic [2:0]  branch_condition;
    logic        branch_check;
    logic        mispredict;
`ifdef BRANCH_STATS_EN
    logic        stats_clear;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    int unsigned m_bcount;
    int unsigned m_mcount;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int m_bht [64];

    always #5 clk = ~clk;

    branch_predict_check #(.WIDTH(32), .PC_WIDTH(32), .BHT_DEPTH(64)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_pred_taken    (id_pred_taken),
        .in1              (in1),
        .in2              (in2),
        .stall_compare    (stall_compare),
        .branch_condition (branch_condition),
`ifdef BRANCH_STATS_EN
        .stats_clear      (stats_clear),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
`endif
        .branch_check     (branch_check),
        .mispredict       (mispredict)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bht_index(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    // Reference condition: plain signed integer comparisons.
    function automatic bit model_cond(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (code)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return sa <= 0;
            3'd4:    return sa > 0;
            3'd5:    return sa < 0;
            3'd6:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
`ifdef BRANCH_STATS_EN
        m_bcount = 0;
        m_mcount = 0;
`endif
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit pt, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] code, input bit st, input logic [31:0] ipc);
        id_valid = v; id_pc = pc; id_pred_taken = pt; in1 = a; in2 = b;
        branch_condition = code; stall_compare = st; if_pc = ipc;
    endtask

    // Check one cycle against the model, then advance the model across the edge.
    task automatic cycle_check(input string tag);
        bit res, c, e_bc, e_mp, e_pt;
        int k;
        #2;
        res  = id_valid && !stall_compare && branch_condition >= 3'd1 && branch_condition <= 3'd6;
        c    = model_cond(branch_condition, in1, in2);
        e_bc = res && c;
        e_mp = res && (c != id_pred_taken);
        e_pt = m_bht[bht_index(if_pc)] >= 2;
        check_val({tag, ".bc"}, {31'd0, branch_check}, {31'd0, e_bc});
        check_val({tag, ".mp"}, {31'd0, mispredict}, {31'd0, e_mp});
        check_val({tag, ".pt"}, {31'd0, pred_taken}, {31'd0, e_pt});
`ifdef BRANCH_STATS_EN
        check_val({tag, ".bcnt"}, branch_count, m_bcount);
        check_val({tag, ".mcnt"}, mispredict_count, m_mcount);
`endif
        @(posedge clk);
        if (res) begin
            k = bht_index(id_pc);
            m_bht[k] = c ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
        end
`ifdef BRANCH_STATS_EN
        if (stats_clear) begin
            m_bcount = 0; m_mcount = 0;
        end else begin
            m_bcount += res ? 1 : 0;
            m_mcount += e_mp ? 1 : 0;
        end
`endif
        #1;
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
`ifdef BRANCH_STATS_EN
        stats_clear = 1'b0;
`endif
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h40);
        model_reset();
        #2;
        check_val("rst.pt", {31'd0, pred_taken}, 32'd0);
        check_val("rst.bc", {31'd0, branch_check}, 32'd0);
        check_val("rst.mp", {31'd0, mispredict}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First taken beq against a fresh entry: mispredict, then entry 10.
        drive(1'b1, 32'h40, 1'b0, 32'd5, 32'd5, 3'd1, 1'b0, 32'h40);
        cycle_check("first");
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h40);
        #2;
        check_val("first.after", {31'd0, pred_taken}, 32'd1);
        #1;
        cycle_check("first.idle");

        // Signed zero-compares on -1 and 0.
        for (int c = 3; c <= 6; c++) begin
            drive(1'b1, 32'h300, 1'b0, 32'hFFFF_FFFF, 32'd7, 3'(c), 1'b0, 32'h300);
            cycle_check("sgn.m1");
            drive(1'b1, 32'h304, 1'b1, 32'h0, 32'd9, 3'(c), 1'b0, 32'h304);
            cycle_check("sgn.zero");
        end

        // Saturation at one PC: five taken, one not-taken, three more, one more.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h80, 1'b1, 32'd1, 32'd2, 3'd2, 1'b0, 32'h80);
            cycle_check("sat.up");
        end
        drive(1'b1, 32'h80, 1'b1, 32'd3, 32'd3, 3'd2, 1'b0, 32'h80);
        cycle_check("sat.dn1");
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h80);
        #2;
        check_val("sat.hold", {31'd0, pred_taken}, 32'd1);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h80, 1'b0, 32'd3, 32'd3, 3'd2, 1'b0, 32'h80);
            cycle_check("sat.dn");
        end
        check_val("sat.floor", m_bht[bht_index(32'h80)], 32'd0);

        // Stalled beq held three cycles, then released once.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hC0, 1'b0, 32'd8, 32'd8, 3'd1, 1'b1, 32'hC0);
            cycle_check("stall");
        end
        drive(1'b1, 32'hC0, 1'b0, 32'd8, 32'd8, 3'd1, 1'b0, 32'hC0);
        cycle_check("stall.rel");
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'hC0);
        cycle_check("stall.after");

        // Aliasing 0x004 / 0x104 with same-cycle update and lookup.
        drive(1'b1, 32'h004, 1'b0, 32'd1, 32'd1, 3'd1, 1'b0, 32'h104);
        #2;
        check_val("alias.old", {31'd0, pred_taken}, 32'd0);
        #1;
        drive(1'b1, 32'h004, 1'b0, 32'd1, 32'd1, 3'd1, 1'b0, 32'h104);
        cycle_check("alias.upd");
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h104);
        #2;
        check_val("alias.new", {31'd0, pred_taken}, 32'd1);
        #1;

        // Reset asserted during a resolve cycle discards the update.
        drive(1'b1, 32'h40, 1'b1, 32'd5, 32'd5, 3'd1, 1'b0, 32'h40);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h40);
        #2;
        check_val("midrst.pt", {31'd0, pred_taken}, 32'd0);
        #1;
        cycle_check("midrst.idle");

`ifdef BRANCH_STATS_EN
        stats_clear = 1'b1;
        cycle_check("st.clr");
        stats_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h200, (i % 4 == 1) ? 1'b0 : 1'b1, 32'd4, 32'd4, 3'd1, 1'b0, 32'h200);
            cycle_check("st.run");
        end
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h200);
        #2;
        check_val("st.bcount10", branch_count, 32'd10);
        check_val("st.mcount3", mispredict_count, 32'd3);
        #1;
        drive(1'b1, 32'h200, 1'b0, 32'd4, 32'd4, 3'd1, 1'b0, 32'h200);
        stats_clear = 1'b1;
        cycle_check("st.clrres");
        stats_clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'h200);
        #2;
        check_val("st.bcount0", branch_count, 32'd0);
        check_val("st.mcount0", mispredict_count, 32'd0);
        #1;
`endif

        // Randomized phase over a small PC pool so aliasing and reuse occur.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h0;
                1:       a = 32'hFFFF_FFFF;
                2:       a = $urandom;
                default: a = 32'd1;
            endcase
            drive($urandom_range(0, 3) != 0,
                  32'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 256)),
                  1'($urandom_range(0, 1)),
                  a,
                  ($urandom_range(0, 1) != 0) ? a : 32'($urandom),
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 4) == 0,
                  32'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 1) * 256)));
`ifdef BRANCH_STATS_EN
            stats_clear = $urandom_range(0, 19) == 0;
`endif
            cycle_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
